// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage (PC, instruction register, valid flag, stall/branch handling).
// Optional macro FETCH_BOUNDS_CHECK_EN adds the PC range check and the HALT state.
`default_nettype none

module fetch_unit #(
   parameter int                     PC_WIDTH    = 8,
   parameter int                     INSTR_WIDTH = 8,
   parameter int                     MEM_DEPTH   = 16,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
   input  logic                      Clock,
   input  logic                      Reset,
   output logic [PC_WIDTH-1:0]       PC,
   input  logic [INSTR_WIDTH-1:0]    Instruction_Code,
   input  logic                      Stall,
   input  logic                      Branch_Taken,
   input  logic [PC_WIDTH-1:0]       Branch_Target,
   output logic [INSTR_WIDTH-1:0]    IR,
   output logic [PC_WIDTH-1:0]       IR_PC,
   output logic                      IR_Valid,
   output logic                      Halted
);

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   // A memory at least as deep as the PC space never makes a PC out of range.
   localparam logic [PC_WIDTH:0] MEM_LIMIT =
      (MEM_DEPTH >= (1 << PC_WIDTH)) ? (PC_WIDTH+1)'(1 << PC_WIDTH)
                                     : (PC_WIDTH+1)'(MEM_DEPTH);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    pc_reg;
   logic [PC_WIDTH-1:0]    pc_next;
   logic                   pc_update;
   logic                   out_of_range;

   always_comb begin
      pc_next      = Branch_Taken ? Branch_Target : (pc_reg + PC_WIDTH'(1));
      pc_update    = Branch_Taken | ~Stall;
      out_of_range = BOUNDS_EN && ({1'b0, pc_next} >= MEM_LIMIT);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= RUN;
         pc_reg   <= RESET_PC;
         IR       <= '0;
         IR_PC    <= '0;
         IR_Valid <= 1'b0;
         Halted   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (Branch_Taken) begin
                  pc_reg   <= pc_next;
                  IR_Valid <= 1'b0;
               end else if (!Stall) begin
                  pc_reg   <= pc_next;
                  IR       <= Instruction_Code;
                  IR_PC    <= pc_reg;
                  IR_Valid <= 1'b1;
               end
               // Halt on the same edge that loads an out-of-range PC.
               if (pc_update && out_of_range) begin
                  state    <= HALT;
                  IR_Valid <= 1'b0;
                  Halted   <= 1'b1;
               end
            end
            HALT: begin
               IR_Valid <= 1'b0;
               Halted   <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   assign PC = pc_reg;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
`default_nettype none

module tb_fetch_unit;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] PC;
   logic [7:0] Instruction_Code;
   logic       Stall = 1'b0;
   logic       Branch_Taken = 1'b0;
   logic [7:0] Branch_Target = 8'h00;
   logic [7:0] IR;
   logic [7:0] IR_PC;
   logic       IR_Valid;
   logic       Halted;

   logic [7:0] mem [0:255];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clock = ~Clock;

   assign Instruction_Code = mem[PC];

   fetch_unit #(
      .PC_WIDTH(8), .INSTR_WIDTH(8), .MEM_DEPTH(16), .RESET_PC(8'h00)
   ) dut (
      .Clock(Clock), .Reset(Reset), .PC(PC), .Instruction_Code(Instruction_Code),
      .Stall(Stall), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
      .IR(IR), .IR_PC(IR_PC), .IR_Valid(IR_Valid), .Halted(Halted)
   );

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0;
      step(); step();
      n_checks++; if (PC !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", PC); end
      n_checks++; if (IR !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h want 00", IR); end
      n_checks++; if (IR_PC !== 8'h00) begin n_fail++; $display("FAIL reset_ir_pc: got %h want 00", IR_PC); end
      n_checks++; if (IR_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", IR_Valid); end
      n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", Halted); end
      Reset = 1'b0;
   endtask

   task automatic test_fetch_sequence();
      logic [7:0] exp [0:5];
      exp[0] = 8'h2b; exp[1] = 8'h6a; exp[2] = 8'h63;
      exp[3] = 8'hc1; exp[4] = 8'h14; exp[5] = 8'h55;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++; if (IR !== exp[i]) begin n_fail++; $display("FAIL seq_ir[%0d]: got %h want %h", i, IR, exp[i]); end
         n_checks++; if (IR_PC !== 8'(i)) begin n_fail++; $display("FAIL seq_ir_pc[%0d]: got %h want %h", i, IR_PC, 8'(i)); end
         n_checks++; if (IR_Valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, IR_Valid); end
         n_checks++; if (PC !== 8'(i + 1)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, 8'(i + 1)); end
      end
   endtask

   task automatic test_stall();
      Reset = 1'b1; step(); Reset = 1'b0;
      step(); step(); step();
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (IR !== 8'h63) begin n_fail++; $display("FAIL stall_ir[%0d]: got %h want 63", i, IR); end
         n_checks++; if (IR_PC !== 8'h02) begin n_fail++; $display("FAIL stall_ir_pc[%0d]: got %h want 02", i, IR_PC); end
         n_checks++; if (PC !== 8'h03) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 03", i, PC); end
         n_checks++; if (IR_Valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, IR_Valid); end
      end
      Stall = 1'b0;
      step();
      n_checks++; if (IR !== 8'hc1) begin n_fail++; $display("FAIL stall_next_ir: got %h want c1", IR); end
      n_checks++; if (IR_PC !== 8'h03) begin n_fail++; $display("FAIL stall_next_ir_pc: got %h want 03", IR_PC); end
      n_checks++; if (PC !== 8'h04) begin n_fail++; $display("FAIL stall_next_pc: got %h want 04", PC); end
   endtask

   task automatic test_branch();
      for (int rep = 0; rep < 2; rep++) begin
         Branch_Taken = 1'b1; Branch_Target = 8'h01; Stall = (rep == 1);
         step();
         n_checks++; if (PC !== 8'h01) begin n_fail++; $display("FAIL br%0d_pc: got %h want 01", rep, PC); end
         n_checks++; if (IR_Valid !== 1'b0) begin n_fail++; $display("FAIL br%0d_bubble: got %b want 0", rep, IR_Valid); end
         n_checks++; if (IR !== 8'hc1) begin n_fail++; $display("FAIL br%0d_ir_hold: got %h want c1", rep, IR); end
         n_checks++; if (IR_PC !== 8'h03) begin n_fail++; $display("FAIL br%0d_ir_pc_hold: got %h want 03", rep, IR_PC); end
         Branch_Taken = 1'b0; Stall = 1'b0;
         step();
         n_checks++; if (IR !== 8'h6a) begin n_fail++; $display("FAIL br%0d_target_ir: got %h want 6a", rep, IR); end
         n_checks++; if (IR_PC !== 8'h01) begin n_fail++; $display("FAIL br%0d_target_ir_pc: got %h want 01", rep, IR_PC); end
         n_checks++; if (IR_Valid !== 1'b1) begin n_fail++; $display("FAIL br%0d_target_valid: got %b want 1", rep, IR_Valid); end
         n_checks++; if (PC !== 8'h02) begin n_fail++; $display("FAIL br%0d_target_pc: got %h want 02", rep, PC); end
         step(); step();
      end
   endtask

   task automatic test_back_to_back();
      Branch_Taken = 1'b1; Branch_Target = 8'h05;
      step();
      n_checks++; if (PC !== 8'h05) begin n_fail++; $display("FAIL b2b_first_pc: got %h want 05", PC); end
      Branch_Target = 8'h00;
      step();
      n_checks++; if (PC !== 8'h00) begin n_fail++; $display("FAIL b2b_second_pc: got %h want 00", PC); end
      n_checks++; if (IR_Valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %b want 0", IR_Valid); end
      Branch_Taken = 1'b0;
      step();
      n_checks++; if (IR !== 8'h2b) begin n_fail++; $display("FAIL b2b_ir: got %h want 2b", IR); end
      n_checks++; if (IR_PC !== 8'h00) begin n_fail++; $display("FAIL b2b_ir_pc: got %h want 00", IR_PC); end
      n_checks++; if (IR_Valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", IR_Valid); end
   endtask

`ifdef FETCH_BOUNDS_CHECK_EN
   task automatic test_bounds();
      Branch_Taken = 1'b1; Branch_Target = 8'h0e;
      step();
      Branch_Taken = 1'b0;
      step();
      n_checks++; if (PC !== 8'h0f || Halted !== 1'b0) begin n_fail++; $display("FAIL bnd_pre: got pc=%h halted=%b want pc=0f halted=0", PC, Halted); end
      step();
      n_checks++; if (PC !== 8'h10) begin n_fail++; $display("FAIL bnd_pc: got %h want 10", PC); end
      n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL bnd_halted: got %b want 1", Halted); end
      n_checks++; if (IR_Valid !== 1'b0) begin n_fail++; $display("FAIL bnd_valid: got %b want 0", IR_Valid); end
      n_checks++; if (IR_PC !== 8'h0f) begin n_fail++; $display("FAIL bnd_ir_pc: got %h want 0f", IR_PC); end
      Branch_Target = 8'h03;
      for (int i = 0; i < 4; i++) begin
         Stall = i[0]; Branch_Taken = i[1];
         step();
         n_checks++; if (PC !== 8'h10 || Halted !== 1'b1 || IR_Valid !== 1'b0) begin
            n_fail++; $display("FAIL bnd_hold[%0d]: got pc=%h halted=%b valid=%b want pc=10 halted=1 valid=0", i, PC, Halted, IR_Valid);
         end
      end
      Reset = 1'b1; Stall = 1'b1; Branch_Taken = 1'b1;
      step();
      n_checks++; if (PC !== 8'h00 || IR !== 8'h00 || IR_Valid !== 1'b0 || Halted !== 1'b0) begin
         n_fail++; $display("FAIL bnd_reset: got pc=%h ir=%h valid=%b halted=%b want 00 00 0 0", PC, IR, IR_Valid, Halted);
      end
      Reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
      step();
      n_checks++; if (IR !== 8'h2b || IR_Valid !== 1'b1 || PC !== 8'h01) begin
         n_fail++; $display("FAIL bnd_resume: got ir=%h valid=%b pc=%h want 2b 1 01", IR, IR_Valid, PC);
      end
      Branch_Taken = 1'b1; Branch_Target = 8'h20;
      step();
      Branch_Taken = 1'b0;
      n_checks++; if (PC !== 8'h20 || Halted !== 1'b1 || IR_Valid !== 1'b0) begin
         n_fail++; $display("FAIL bnd_branch_out: got pc=%h halted=%b valid=%b want 20 1 0", PC, Halted, IR_Valid);
      end
      step();
      n_checks++; if (PC !== 8'h20 || Halted !== 1'b1) begin n_fail++; $display("FAIL bnd_branch_hold: got pc=%h halted=%b want 20 1", PC, Halted); end
      Reset = 1'b1; step(); Reset = 1'b0;
   endtask
`else
   task automatic test_wrap();
      Branch_Taken = 1'b1; Branch_Target = 8'hfe;
      step();
      Branch_Taken = 1'b0;
      n_checks++; if (PC !== 8'hfe) begin n_fail++; $display("FAIL wrap_fe: got %h want fe", PC); end
      step();
      n_checks++; if (PC !== 8'hff || IR_PC !== 8'hfe || IR !== mem[8'hfe]) begin
         n_fail++; $display("FAIL wrap_ff: got pc=%h ir_pc=%h ir=%h want ff fe %h", PC, IR_PC, IR, mem[8'hfe]);
      end
      step();
      n_checks++; if (PC !== 8'h00 || IR_PC !== 8'hff) begin n_fail++; $display("FAIL wrap_00: got pc=%h ir_pc=%h want 00 ff", PC, IR_PC); end
      step();
      n_checks++; if (PC !== 8'h01 || IR !== 8'h2b || IR_Valid !== 1'b1) begin
         n_fail++; $display("FAIL wrap_01: got pc=%h ir=%h valid=%b want 01 2b 1", PC, IR, IR_Valid);
      end
      n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %b want 0", Halted); end
   endtask
`endif

   task automatic test_reset_midrun();
      step(); step();
      Reset = 1'b1; Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 8'h09;
      step();
      n_checks++; if (PC !== 8'h00 || IR !== 8'h00 || IR_PC !== 8'h00 || IR_Valid !== 1'b0 || Halted !== 1'b0) begin
         n_fail++; $display("FAIL midrun_reset: got pc=%h ir=%h ir_pc=%h valid=%b halted=%b want 00 00 00 0 0", PC, IR, IR_PC, IR_Valid, Halted);
      end
      Reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
      step();
      n_checks++; if (IR !== 8'h2b || IR_Valid !== 1'b1 || PC !== 8'h01) begin
         n_fail++; $display("FAIL midrun_resume: got ir=%h valid=%b pc=%h want 2b 1 01", IR, IR_Valid, PC);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'ha5;
      mem[0] = 8'h2b; mem[1] = 8'h6a; mem[2] = 8'h63;
      mem[3] = 8'hc1; mem[4] = 8'h14; mem[5] = 8'h55;

      test_reset();
      test_fetch_sequence();
      test_stall();
      test_branch();
      test_back_to_back();
`ifdef FETCH_BOUNDS_CHECK_EN
      test_bounds();
`else
      test_wrap();
`endif
      test_reset_midrun();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
